// File: rtl/pipelined_prefix_add.sv
// rtl/pipelined_prefix_add.sv - Kogge-Stone add/subtract with a valid/ready register pipeline
module pipelined_prefix_add #(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co,
    output logic         ovf
);

    localparam int L = $clog2(N);

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic [N-1:0] gp;
        logic         cin;
    } pfx_t;

    typedef struct packed {
        logic [N-1:0] c;
        logic         co;
        logic         ovf;
    } res_t;

    // Carry-in enters as the generate of position -1, folded into bit 0.
    function automatic pfx_t pfx_init(logic [N-1:0] av, logic [N-1:0] bv, logic cv);
        pfx_t s;
        s.p     = av ^ bv;
        s.g     = av & bv;
        s.gp    = s.p;
        s.cin   = cv;
        s.g[0]  = s.g[0] | (s.p[0] & cv);
        s.gp[0] = 1'b0;
        return s;
    endfunction

    function automatic pfx_t pfx_level(pfx_t s, int d);
        pfx_t r;
        r = s;
        for (int i = d; i < N; i++) begin
            r.g[i]  = s.g[i] | (s.gp[i] & s.g[i-d]);
            r.gp[i] = s.gp[i] & s.gp[i-d];
        end
        return r;
    endfunction

    function automatic res_t pfx_final(logic [N-1:0] p, logic [N-1:0] g, logic cin);
        res_t         r;
        logic [N-1:0] cy;
        cy    = {g[N-2:0], cin};
        r.c   = p ^ cy;
        r.co  = g[N-1];
        r.ovf = cy[N-1] ^ g[N-1];
        return r;
    endfunction

    // Bit j set when an intermediate rank sits in front of prefix level j;
    // earlier segments absorb the remainder levels.
    function automatic logic [L-1:0] bnd_mask();
        logic [L-1:0] msk;
        int           q;
        int           r;
        int           st;
        msk = '0;
        if (STAGES > 2) begin
            q = L / (STAGES - 1);
            r = L % (STAGES - 1);
            for (int m = 1; m <= STAGES - 2; m++) begin
                st      = m * q + ((m < r) ? m : r);
                msk[st] = 1'b1;
            end
        end
        return msk;
    endfunction

    localparam logic [L-1:0] BND = bnd_mask();

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] adv;

    always_comb begin
        adv = '0;
        ld  = '0;
        adv[STAGES-1] = vld_q[STAGES-1] & out_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            ld[k]    = vld_q[k-1] & (~vld_q[k] | adv[k]);
            adv[k-1] = vld_q[k-1] & ld[k];
        end
        in_ready = ~vld_q[0] | adv[0];
        ld[0]    = in_valid & in_ready;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = ld[k] | (vld_q[k] & ~adv[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    logic [N-1:0] bb;
    logic         cin;
    logic [N-1:0] src_a;
    logic [N-1:0] src_bb;
    logic         src_cin;

    assign bb  = sub ? ~b : b;
    assign cin = sub ? 1'b1 : ci;

    generate
        if (STAGES == 1) begin : g_single
            assign src_a   = a;
            assign src_bb  = bb;
            assign src_cin = cin;
        end else begin : g_multi
            logic [N-1:0] a_q;
            logic [N-1:0] bb_q;
            logic         cin_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    bb_q  <= '0;
                    cin_q <= 1'b0;
                end else if (ld[0]) begin
                    a_q   <= a;
                    bb_q  <= bb;
                    cin_q <= cin;
                end
            end

            assign src_a   = a_q;
            assign src_bb  = bb_q;
            assign src_cin = cin_q;
        end
    endgenerate

    pfx_t mid_q [STAGES];
    pfx_t mid_d [STAGES];
    res_t res_d;
    res_t res_q;

    always_comb begin
        pfx_t s;
        int   m;
        for (int k = 0; k < STAGES; k++) begin
            mid_d[k] = '0;
        end
        s = pfx_init(src_a, src_bb, src_cin);
        m = 0;
        for (int j = 0; j < L; j++) begin
            if (BND[j]) begin
                m        = m + 1;
                mid_d[m] = s;
                s        = mid_q[m];
            end
            s = pfx_level(s, 1 << j);
        end
        res_d = pfx_final(s.p, s.g, s.cin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                mid_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < STAGES - 1; k++) begin
                if (ld[k]) begin
                    mid_q[k] <= mid_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (ld[STAGES-1]) begin
            res_q <= res_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign c         = res_q.c;
    assign co        = res_q.co;
    assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_pipelined_prefix_add.sv
// tb/tb_pipelined_prefix_add.sv - directed and randomized bench over several N/STAGES instances
module tb_pipelined_prefix_add;

    localparam int NI = 5;
    localparam int NW [NI] = '{32, 4, 4, 16, 64};
    localparam int SG [NI] = '{2, 1, 3, 4, 5};

    typedef struct {
        logic [65:0] exp;
        int          cyc;
        bit          seen;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        ci;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  sel;

    logic [NI-1:0] iv;
    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] co_v;
    logic [NI-1:0] ovf_v;
    logic [31:0]   c0;
    logic [3:0]    c1;
    logic [3:0]    c2;
    logic [15:0]   c3;
    logic [63:0]   c4;

    logic        in_ready_m;
    logic        out_valid_m;
    logic        co_m;
    logic        ovf_m;
    logic [63:0] c_m;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   lat_chk = 1'b0;
    bit   hold_prev = 1'b0;
    bit   last_acc = 1'b0;
    ent_t q[$];

    always #5 clk = ~clk;

    always_comb begin
        iv      = '0;
        iv[sel] = in_valid;
    end

    always_comb begin
        in_ready_m  = ir[sel];
        out_valid_m = ov[sel];
        co_m        = co_v[sel];
        ovf_m       = ovf_v[sel];
        case (sel)
            3'd0:    c_m = {32'h0, c0};
            3'd1:    c_m = {60'h0, c1};
            3'd2:    c_m = {60'h0, c2};
            3'd3:    c_m = {48'h0, c3};
            default: c_m = c4;
        endcase
    end

    pipelined_prefix_add #(.N(32), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[31:0]), .b(b[31:0]),
        .ci(ci), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .c(c0), .co(co_v[0]), .ovf(ovf_v[0]));
    pipelined_prefix_add #(.N(4), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[3:0]), .b(b[3:0]),
        .ci(ci), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .c(c1), .co(co_v[1]), .ovf(ovf_v[1]));
    pipelined_prefix_add #(.N(4), .STAGES(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a[3:0]), .b(b[3:0]),
        .ci(ci), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .c(c2), .co(co_v[2]), .ovf(ovf_v[2]));
    pipelined_prefix_add #(.N(16), .STAGES(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a[15:0]), .b(b[15:0]),
        .ci(ci), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready), .c(c3), .co(co_v[3]), .ovf(ovf_v[3]));
    pipelined_prefix_add #(.N(64), .STAGES(5)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(ov[4]), .out_ready(out_ready), .c(c4), .co(co_v[4]), .ovf(ovf_v[4]));

    // Reference: plain unsigned and signed integer arithmetic at width n.
    function automatic logic [65:0] ref_model(int n, logic [63:0] av, logic [63:0] bv, logic civ, logic subv);
        logic [63:0]        mask;
        logic [64:0]        ua;
        logic [64:0]        ub;
        logic [64:0]        us;
        logic               co_r;
        logic               ovf_r;
        logic signed [66:0] sa;
        logic signed [66:0] sb;
        logic signed [66:0] ss;
        logic signed [66:0] lim;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        ua   = {1'b0, av & mask};
        ub   = {1'b0, bv & mask};
        sa   = $signed({2'b00, ua});
        sb   = $signed({2'b00, ub});
        if (av[n-1]) sa = sa - (67'sd1 <<< n);
        if (bv[n-1]) sb = sb - (67'sd1 <<< n);
        if (subv) begin
            us   = ua - ub;
            co_r = (ua >= ub);
            ss   = sa - sb;
        end else begin
            us   = ua + ub + 65'(civ);
            co_r = ((us >> n) != 65'd0);
            ss   = sa + sb + 67'(civ);
        end
        lim   = 67'sd1 <<< (n - 1);
        ovf_r = (ss >= lim) || (ss < -lim);
        return {ovf_r, co_r, us[63:0] & mask};
    endfunction

    task automatic chk(string tag, logic [65:0] got, logic [65:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_rand(bit v);
        in_valid = v;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        ci       = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        last_acc = in_valid && in_ready_m;
        if (hold_prev) chk("hold_valid", 66'(out_valid_m), 66'd1);
        if (out_valid_m) begin
            if (q.size() == 0) begin
                chk("spurious_out", 66'(out_valid_m), 66'd0);
            end else begin
                chk("result", {ovf_m, co_m, c_m}, q[0].exp);
                if (lat_chk && !q[0].seen) chk("latency", 66'(cyc - q[0].cyc), 66'(SG[sel]));
                q[0].seen = 1'b1;
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        hold_prev = out_valid_m && !out_ready;
        if (last_acc) q.push_back('{ref_model(NW[sel], a, b, ci, sub), cyc, 1'b0});
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && q.size() != 0; i++) tick();
        chk("drain_empty", 66'(q.size()), 66'd0);
    endtask

    task automatic directed(string tag, logic [31:0] av, logic [31:0] bv, logic civ, logic subv,
                            logic [31:0] ec, logic eco, logic eovf);
        int n;
        a         = {32'h0, av};
        b         = {32'h0, bv};
        ci        = civ;
        sub       = subv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({tag, "_ready"}, 66'(in_ready_m), 66'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid_m && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 66'(n), 66'(SG[0]));
        chk(tag, {ovf_m, co_m, c_m}, {eovf, eco, 32'h0, ec});
        @(negedge clk);
    endtask

    initial begin
        int n0;
        int g;
        rst       = 1'b1;
        sel       = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;

        repeat (2) @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            sel = 3'(s);
            #1;
            chk("rst_out_valid", 66'(out_valid_m), 66'd0);
            chk("rst_result", {ovf_m, co_m, c_m}, 66'd0);
            chk("rst_in_ready", 66'(in_ready_m), 66'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 3'd0;

        directed("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        directed("sub_borrow",  32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        directed("add_ci_ovf",  32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        directed("sub_ci_ign",  32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);

        for (int s = 0; s < NI; s++) begin
            sel       = 3'(s);
            lat_chk   = 1'b1;
            out_ready = 1'b1;
            n0        = n_out;
            g         = (s == 0) ? 100 : 20;
            for (int i = 0; i < g; i++) begin
                set_rand(1'b1);
                tick();
                chk("stream_accept", 66'(last_acc), 66'd1);
            end
            drain();
            chk("stream_count", 66'(n_out - n0), 66'(g));
            lat_chk = 1'b0;
            for (int i = 0; i < 300; i++) begin
                set_rand($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            drain();
            if (NW[s] == 4) begin
                for (int x = 0; x < 1024; x++) begin
                    a         = {60'h0, 4'(x)};
                    b         = {60'h0, 4'(x >> 4)};
                    ci        = 1'(x >> 8);
                    sub       = 1'(x >> 9);
                    in_valid  = 1'b1;
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                    for (int k = 0; k < 20 && !last_acc; k++) begin
                        out_ready = 1'($urandom_range(0, 1));
                        tick();
                    end
                    chk("exh_accept", 66'(last_acc), 66'd1);
                end
                drain();
            end
        end

        sel       = 3'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rand(1'b1);
            tick();
        end
        chk("stall_accepted", 66'(q.size()), 66'(SG[0]));
        set_rand(1'b1);
        tick();
        chk("stall_in_ready", 66'(last_acc), 66'd0);
        tick();
        out_ready = 1'b1;
        set_rand(1'b1);
        tick();
        chk("full_accept_consume", 66'(last_acc), 66'd1);
        for (int i = 0; i < 5; i++) begin
            set_rand(1'b1);
            tick();
        end
        drain();

        out_ready = 1'b0;
        set_rand(1'b1);
        tick();
        set_rand(1'b1);
        tick();
        in_valid = 1'b0;
        chk("rst_inflight", 66'(q.size()), 66'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 66'(out_valid_m), 66'd0);
        chk("midrst_result", {ovf_m, co_m, c_m}, 66'd0);
        chk("midrst_in_ready", 66'(in_ready_m), 66'd1);
        q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_idle", 66'(out_valid_m), 66'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
